// File: rtl/encoder_if.sv
// encoder_if: transmit-side bundle between the GMII-facing logic and the PCS
// transmit encoder, plus the 4D PAM5 symbol lanes going to the PMA/DAC.
//   io_tx_enable        frame-active strobe (GMII TX_EN)
//   io_tx_mode          1 = SEND_N (normal), 0 = SEND_Z (transmit zeros)
//   io_tx_error         GMII TX_ER
//   io_tx_data[7:0]     transmit byte
//   io_n[31:0]          free-running symbol counter
//   io_n0[31:0]         scrambler reload time and seed
//   io_loc_rcvr_status  1 = local receiver OK
//   io_A..io_D[2:0]     two's-complement PAM5 symbols (+2..-2)
interface encoder_if;
  logic        io_tx_enable;
  logic        io_tx_mode;
  logic        io_tx_error;
  logic [7:0]  io_tx_data;
  logic [31:0] io_n;
  logic [31:0] io_n0;
  logic        io_loc_rcvr_status;
  logic [2:0]  io_A;
  logic [2:0]  io_B;
  logic [2:0]  io_C;
  logic [2:0]  io_D;

  modport master (
    output io_tx_enable, io_tx_mode, io_tx_error, io_tx_data,
           io_n, io_n0, io_loc_rcvr_status,
    input  io_A, io_B, io_C, io_D
  );

  modport slave (
    input  io_tx_enable, io_tx_mode, io_tx_error, io_tx_data,
           io_n, io_n0, io_loc_rcvr_status,
    output io_A, io_B, io_C, io_D
  );
endinterface

// File: rtl/encoder.sv
// encoder: 1000BASE-T-style PCS transmit encoder. One byte per clock in, one
// registered 4D PAM5 symbol (lanes A..D) per clock out.
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    encoder_if.slave: transmit controls/data in, symbol lanes out
// MASTER selects the side-stream scrambler polynomial:
//   1 = 1+x^13+x^33, 0 = 1+x^20+x^33.
// The symbol registered at an edge is the one belonging to the state being
// entered at that edge, so SSD1 appears right after TX_EN is first sampled.
module encoder #(
  parameter bit MASTER = 1'b1
) (
  input  logic     clock,
  input  logic     reset,
  encoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SSD1, SSD2, DATA, CSR1, CSR2, ESD1, ESD2
  } state_t;

  localparam logic [2:0] SYM_P2 = 3'b010;
  localparam logic [2:0] SYM_P1 = 3'b001;
  localparam logic [2:0] SYM_Z  = 3'b000;
  localparam logic [2:0] SYM_M1 = 3'b111;
  localparam logic [2:0] SYM_M2 = 3'b110;

  state_t            state_q, state_d;
  logic [32:0]       scr_q, scr_d;
  logic [2:0]        cs_q, cs_d;
  logic [3:0][2:0]   sym_q, sym_d;   // index 0 = lane A

  logic        fb;
  logic [3:0]  sx, sy;
  logic [7:0]  sd;
  logic        upd_cs;

  // PAM5 lane mapping; p=1 removes the outer levels on lane A and negates
  // the other three lanes so the parity is carried by the symbol subset.
  function automatic logic [2:0] map_lane(input logic lane_a, input logic p,
                                          input logic [1:0] v);
    logic [2:0] s;
    case (v)
      2'b00:   s = SYM_P2;
      2'b01:   s = SYM_P1;
      2'b10:   s = SYM_M1;
      default: s = SYM_M2;
    endcase
    if (p) begin
      if (lane_a) s = (v == 2'b01) ? SYM_P1 : (v == 2'b10) ? SYM_M1 : SYM_Z;
      else        s = 3'(~s + 3'd1);
    end
    return s;
  endfunction

  // Side-stream scrambler and its derived bits.
  always_comb begin
    fb = MASTER ? (scr_q[12] ^ scr_q[32]) : (scr_q[19] ^ scr_q[32]);
    if (bus.io_n == bus.io_n0) scr_d = {1'b1, bus.io_n0};
    else                       scr_d = {scr_q[31:0], fb};

    sy = {scr_q[9] ^ scr_q[14] ^ scr_q[19] ^ scr_q[24],
          scr_q[6] ^ scr_q[16],
          scr_q[3] ^ scr_q[8],
          scr_q[0]};
    sx = {scr_q[13] ^ scr_q[15] ^ scr_q[23] ^ scr_q[25],
          scr_q[10] ^ scr_q[12] ^ scr_q[20] ^ scr_q[22],
          scr_q[7] ^ scr_q[9] ^ scr_q[12] ^ scr_q[14],
          scr_q[4] ^ scr_q[6]};
  end

  // Framing FSM, symbol generation and convolutional encoder.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave a value unassigned (no latches).
    state_d = state_q;
    sd      = 8'h00;
    upd_cs  = 1'b0;
    cs_d    = 3'b000;
    sym_d   = '0;

    case (state_q)
      IDLE: if (bus.io_tx_enable && bus.io_loc_rcvr_status) state_d = SSD1;
      SSD1: state_d = SSD2;
      SSD2: state_d = DATA;
      DATA: state_d = bus.io_tx_enable ? DATA : CSR1;
      CSR1: state_d = CSR2;
      CSR2: state_d = ESD1;
      ESD1: state_d = ESD2;
      default: state_d = IDLE;
    endcase
    if (!bus.io_tx_mode) state_d = IDLE;

    case (state_d)
      IDLE: begin
        for (int k = 0; k < 4; k++)
          sym_d[k] = sx[k] ? SYM_Z : (sy[k] ? SYM_M2 : SYM_P2);
      end
      SSD1, ESD1: sym_d = {SYM_P2, SYM_P2, SYM_P2, SYM_P2};
      SSD2:       sym_d = {SYM_M2, SYM_P2, SYM_P2, SYM_P2};
      ESD2: begin
        if (bus.io_tx_error) sym_d = {SYM_P2, SYM_P2, SYM_P2, SYM_M2};
        else                 sym_d = {SYM_M2, SYM_P2, SYM_P2, SYM_P2};
      end
      DATA: begin
        upd_cs = 1'b1;
        if (bus.io_tx_error) begin
          // Error symbol; the trellis still advances with Sd[7:6] = 0.
          sym_d = {SYM_P2, SYM_P2, SYM_P2, SYM_M2};
        end else begin
          sd = bus.io_tx_data ^ {sx, sy};
          for (int k = 0; k < 4; k++)
            sym_d[k] = map_lane(k == 0, cs_q[0], sd[2*k +: 2]);
        end
      end
      default: begin  // CSR1, CSR2: feeding cs back drives it to 000
        upd_cs = 1'b1;
        sd = {cs_q[1], cs_q[0], 6'b0} ^ {2'b00, sx[1:0], sy};
        for (int k = 0; k < 4; k++)
          sym_d[k] = map_lane(k == 0, cs_q[0], sd[2*k +: 2]);
      end
    endcase

    if (upd_cs) cs_d = {sd[7] ^ cs_q[1], sd[6] ^ cs_q[0], cs_q[2]};
    if (!bus.io_tx_mode) sym_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      scr_q   <= '1;
      cs_q    <= 3'b000;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cs_q    <= cs_d;
      sym_q   <= sym_d;
    end
  end

  assign bus.io_A = sym_q[0];
  assign bus.io_B = sym_q[1];
  assign bus.io_C = sym_q[2];
  assign bus.io_D = sym_q[3];

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed self-checking bench for the PCS transmit encoder.
// Symbols are compared as {A,B,C,D}; hand constants are used for delimiters,
// error symbols and the first idle symbol, and a small behavioural model
// supplies the scrambled idle/data/CSReset symbols.
module tb_encoder;

  localparam logic [11:0] S_SSD1 = 12'h492;  // (+2,+2,+2,+2)
  localparam logic [11:0] S_SSD2 = 12'h496;  // (+2,+2,+2,-2)
  localparam logic [11:0] S_ERR  = 12'hC92;  // (-2,+2,+2,+2)
  localparam logic [31:0] FAR_N0 = 32'hDEAD_BEEF;

  typedef enum int {M_IDLE, M_SSD1, M_SSD2, M_DATA,
                    M_CSR1, M_CSR2, M_ESD1, M_ESD2} mst_t;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  encoder_if bus();

  encoder #(.MASTER(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state.
  logic [32:0] m_scr;
  logic [2:0]  m_cs;
  mst_t        m_st;
  logic [2:0]  tab_n [4] = '{3'b010, 3'b001, 3'b111, 3'b110};
  logic [2:0]  tab_p [4] = '{3'b110, 3'b111, 3'b001, 3'b010};

  function automatic logic [2:0] m_lane(int k, logic p, logic [1:0] v);
    if (!p) return tab_n[v];
    if (k == 0) return (v == 2'b01) ? 3'b001 : (v == 2'b10) ? 3'b111 : 3'b000;
    return tab_p[v];
  endfunction

  task automatic model_reset();
    m_scr = '1;
    m_cs  = 3'b000;
    m_st  = M_IDLE;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model(output logic [11:0] e);
    logic [3:0] sx, sy;
    logic [7:0] sd;
    logic [2:0] l [4];
    mst_t       nst;
    bit         upd;
    sy = {m_scr[9]^m_scr[14]^m_scr[19]^m_scr[24], m_scr[6]^m_scr[16],
          m_scr[3]^m_scr[8], m_scr[0]};
    sx = {m_scr[13]^m_scr[15]^m_scr[23]^m_scr[25],
          m_scr[10]^m_scr[12]^m_scr[20]^m_scr[22],
          m_scr[7]^m_scr[9]^m_scr[12]^m_scr[14], m_scr[4]^m_scr[6]};
    case (m_st)
      M_IDLE: nst = (bus.io_tx_enable && bus.io_loc_rcvr_status) ? M_SSD1 : M_IDLE;
      M_SSD1: nst = M_SSD2;
      M_SSD2: nst = M_DATA;
      M_DATA: nst = bus.io_tx_enable ? M_DATA : M_CSR1;
      M_CSR1: nst = M_CSR2;
      M_CSR2: nst = M_ESD1;
      M_ESD1: nst = M_ESD2;
      default: nst = M_IDLE;
    endcase
    if (!bus.io_tx_mode) nst = M_IDLE;
    upd = 0;
    sd  = 8'h00;
    for (int k = 0; k < 4; k++) l[k] = 3'b010;
    case (nst)
      M_IDLE: for (int k = 0; k < 4; k++)
                l[k] = sx[k] ? 3'b000 : (sy[k] ? 3'b110 : 3'b010);
      M_SSD2: l[3] = 3'b110;
      M_ESD2: if (bus.io_tx_error) l[0] = 3'b110; else l[3] = 3'b110;
      M_DATA: begin
        upd = 1;
        if (bus.io_tx_error) l[0] = 3'b110;
        else begin
          sd = bus.io_tx_data ^ {sx, sy};
          for (int k = 0; k < 4; k++) l[k] = m_lane(k, m_cs[0], sd[2*k +: 2]);
        end
      end
      M_CSR1, M_CSR2: begin
        upd = 1;
        sd = {m_cs[1], m_cs[0], 6'b0} ^ {2'b00, sx[1:0], sy};
        for (int k = 0; k < 4; k++) l[k] = m_lane(k, m_cs[0], sd[2*k +: 2]);
      end
      default: ;
    endcase
    e = {l[0], l[1], l[2], l[3]};
    if (!bus.io_tx_mode) e = 12'h000;
    m_cs = upd ? {sd[7] ^ m_cs[1], sd[6] ^ m_cs[0], m_cs[2]} : 3'b000;
    if (bus.io_n == bus.io_n0) m_scr = {1'b1, bus.io_n0};
    else                       m_scr = {m_scr[31:0], m_scr[12] ^ m_scr[32]};
    m_st = nst;
  endtask

  function automatic logic [11:0] obs();
    return {bus.io_A, bus.io_B, bus.io_C, bus.io_D};
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: model predicts, DUT is sampled 1 time unit after the edge.
  task automatic step(input string tag);
    logic [11:0] e;
    model(e);
    @(posedge clock);
    #1;
    check(tag, obs(), e);
    bus.io_n = bus.io_n + 32'd1;
  endtask

  // Same as step, plus a comparison against a hand-computed symbol.
  task automatic step_h(input string tag, input logic [11:0] hand);
    step(tag);
    check({tag, "_hand"}, obs(), hand);
  endtask

  function automatic bit idle_levels_ok();
    logic [11:0] s;
    s = obs();
    for (int k = 0; k < 4; k++)
      if (!(s[3*k +: 3] inside {3'b010, 3'b000, 3'b110})) return 0;
    return 1;
  endfunction

  initial begin
    bus.io_tx_enable       = 1'b0;
    bus.io_tx_mode         = 1'b1;
    bus.io_tx_error        = 1'b0;
    bus.io_tx_data         = 8'h00;
    bus.io_n               = 32'd0;
    bus.io_n0              = FAR_N0;
    bus.io_loc_rcvr_status = 1'b1;
    reset                  = 1'b1;
    model_reset();

    // Reset held for 4 cycles: outputs stay zero.
    repeat (4) @(posedge clock);
    #1;
    check("reset_syms", obs(), 12'h000);
    check("reset_cs", dut.cs_q, 3'b000);
    check("reset_scr", dut.scr_q, {33{1'b1}});
    reset = 1'b0;

    // Idle from Scr = all ones.
    step_h("idle_first", S_ERR);
    for (int i = 0; i < 6; i++) begin
      step("idle");
      check("idle_levels", idle_levels_ok(), 1'b1);
    end

    // Long frame: 256 bytes 0..255, cs tracked every cycle.
    bus.io_tx_enable = 1'b1;
    bus.io_tx_data   = 8'h55;        // preamble, discarded
    step_h("ssd1", S_SSD1);
    step_h("ssd2", S_SSD2);
    for (int b = 0; b < 256; b++) begin
      bus.io_tx_data = 8'(b);
      step("data");
      check("data_cs", dut.cs_q, m_cs);
    end
    bus.io_tx_enable = 1'b0;
    step("csr1");
    step("csr2");
    check("csr_cs_zero", dut.cs_q, 3'b000);
    step_h("esd1", S_SSD1);
    step_h("esd2", S_SSD2);
    step("idle_after_frame");
    check("idle_after_levels", idle_levels_ok(), 1'b1);

    // Short frame: 4 bytes, TX_ER on one data byte and on ESD2.
    bus.io_tx_enable = 1'b1;
    step_h("s_ssd1", S_SSD1);
    step_h("s_ssd2", S_SSD2);
    bus.io_tx_data = 8'hA5; step("s_data0");
    bus.io_tx_data = 8'h3C; step("s_data1");
    bus.io_tx_error = 1'b1;
    bus.io_tx_data = 8'hFF; step_h("s_data_err", S_ERR);
    bus.io_tx_error = 1'b0;
    bus.io_tx_data = 8'h0F; step("s_data3");
    check("s_cs", dut.cs_q, m_cs);
    bus.io_tx_enable = 1'b0;
    step("s_csr1");
    bus.io_tx_enable = 1'b1;         // ignored until IDLE
    step("s_csr2");
    check("s_cs_zero", dut.cs_q, 3'b000);
    step_h("s_esd1", S_SSD1);
    bus.io_tx_error = 1'b1;
    step_h("s_esd2_err", S_ERR);
    bus.io_tx_error  = 1'b0;
    bus.io_tx_enable = 1'b0;
    step("s_idle");

    // SEND_Z mid-frame forces zeros and IDLE.
    bus.io_tx_enable = 1'b1;
    step_h("z_ssd1", S_SSD1);
    step_h("z_ssd2", S_SSD2);
    bus.io_tx_data = 8'h81; step("z_data");
    bus.io_tx_mode = 1'b0;
    step_h("z_zero", 12'h000);
    check("z_cs", dut.cs_q, 3'b000);
    bus.io_tx_mode   = 1'b1;
    bus.io_tx_enable = 1'b0;
    step("z_back_idle");
    check("z_idle_levels", idle_levels_ok(), 1'b1);

    // Receiver not OK keeps IDLE despite TX_EN.
    bus.io_loc_rcvr_status = 1'b0;
    bus.io_tx_enable       = 1'b1;
    step("rcvr_bad_idle");
    step("rcvr_bad_idle2");
    bus.io_tx_enable       = 1'b0;
    bus.io_loc_rcvr_status = 1'b1;

    // Scrambler reload when io_n == io_n0.
    bus.io_n0 = bus.io_n;
    step("reload");
    check("reload_scr", dut.scr_q, {1'b1, bus.io_n0});
    bus.io_n0 = FAR_N0;
    step("reload_idle");

    // Reset mid-frame aborts immediately; restart in IDLE.
    bus.io_tx_enable = 1'b1;
    step_h("r_ssd1", S_SSD1);
    step_h("r_ssd2", S_SSD2);
    bus.io_tx_data = 8'h42; step("r_data");
    reset = 1'b1;
    #1;
    check("r_async_zero", obs(), 12'h000);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.io_tx_enable = 1'b0;
    model_reset();
    step_h("r_idle_first", S_ERR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- 1000BASE-T-style PCS transmit encoder: one byte per clock in, one 4D PAM5 symbol per clock out (lanes A–D).
- Contains three parts:
  - a 33-bit side-stream scrambler;
  - a 3-bit convolutional (trellis parity) encoder;
  - a framing FSM that inserts SSD/ESD delimiters, idle, and convolutional-state reset (CSReset) symbols.
- Sits between the GMII-side transmit interface and the PMA/DAC symbol path.

Parameters:
- MASTER, 1, scrambler polynomial select: 1 = 1+x^13+x^33, 0 = 1+x^20+x^33.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- io_tx_enable  in  1  frame-active strobe (GMII TX_EN).
- io_tx_mode  in  1  1 = SEND_N (normal), 0 = SEND_Z (transmit zeros).
- io_tx_error  in  1  GMII TX_ER.
- io_tx_data  in  8  transmit byte.
- io_n  in  32  free-running symbol counter.
- io_n0  in  32  scrambler reload time and seed.
- io_loc_rcvr_status  in  1  1 = local receiver OK; 0 forces idle.
- io_A, io_B, io_C, io_D  out  3 each  signed two's-complement PAM5 symbol: +2=010, +1=001, 0=000, -1=111, -2=110.

Behaviour:
- Reset (asynchronous) values:
  - io_A..io_D = 0.
  - Scrambler Scr[32:0] = all ones.
  - cs[2:0] = 0.
  - FSM = IDLE.
- Latency: all outputs are registered. At each rising edge, the inputs and current state produce the symbol, which appears on io_A..io_D after that edge (1 cycle).
- Scrambler:
  - Advances every cycle: Scr <= {Scr[31:0], fb}.
  - fb = Scr[12]^Scr[32] when MASTER=1, else Scr[19]^Scr[32].
  - Reload: if io_n == io_n0, Scr <= {1'b1, io_n0} instead of advancing.
- Derived scrambler bits:
  - Sy = {Scr[9]^Scr[14]^Scr[19]^Scr[24], Scr[6]^Scr[16], Scr[3]^Scr[8], Scr[0]}.
  - Sx = {Scr[13]^Scr[15]^Scr[23]^Scr[25], Scr[10]^Scr[12]^Scr[20]^Scr[22], Scr[7]^Scr[9]^Scr[12]^Scr[14], Scr[4]^Scr[6]}.
- Convolutional encoder:
  - Parity p = Sd[8] = cs[0].
  - Update: cs[0] <= cs[2]; cs[1] <= Sd[6]^cs[0]; cs[2] <= Sd[7]^cs[1].
  - Updates only in DATA, CSR1 and CSR2; held at 0 in all other states.
- FSM states: IDLE, SSD1, SSD2, DATA, CSR1, CSR2, ESD1, ESD2.
  - IDLE → SSD1 when io_tx_enable & io_tx_mode & io_loc_rcvr_status.
  - SSD1 → SSD2 → DATA unconditionally. The bytes sampled during SSD1 and SSD2 are discarded (they replace preamble).
  - DATA → DATA while io_tx_enable; otherwise → CSR1.
  - CSR1 → CSR2 → ESD1 → ESD2 → IDLE unconditionally. io_tx_enable is ignored until IDLE is reached.
  - io_tx_mode=0 forces IDLE and all-zero symbols, overriding everything else.
  - io_loc_rcvr_status=0 in IDLE keeps IDLE.
- Symbols per state, listed as (A,B,C,D):
  - IDLE: lane k = 0 if Sx[k], else (Sy[k] ? -2 : +2).
  - SSD1 (+2,+2,+2,+2); SSD2 (+2,+2,+2,-2); ESD1 (+2,+2,+2,+2).
  - ESD2: (-2,+2,+2,+2) if io_tx_error sampled, else (+2,+2,+2,-2).
  - DATA with io_tx_error=1: (-2,+2,+2,+2). The convolutional encoder still updates, with Sd[7:6]=0.
  - DATA otherwise: Sd[7:0] = io_tx_data ^ {Sx, Sy}.
  - CSR1/CSR2: Sd[7:0] = {cs[1], cs[0], 6'b0} ^ {0, 0, Sx[1:0], Sy}. This returns cs to 000 after CSR2.
- Lane mapping (DATA/CSR): lane k (A=0..D=3) uses v = Sd[2k+1:2k].
  - p=0: 00→+2, 01→+1, 10→-1, 11→-2.
  - p=1: 00→0, 01→+1, 10→-1, 11→0 for lane A; lanes B–D use the p=0 table negated.
- Reset asserted mid-frame: the frame is aborted immediately. After release the encoder restarts in IDLE.

Test Plan:
- Assert reset 4 cycles, release with io_tx_enable=0 and io_tx_mode=1 → io_A..D = 0 during reset. Afterwards every lane is in {-2, 0, +2} and matches the IDLE formula from Scr=all-ones.
- Raise io_tx_enable at edge k → outputs after edge k = (+2,+2,+2,+2), after edge k+1 = (+2,+2,+2,-2), data symbols from k+2.
- Send bytes 0..255 continuously → each symbol matches a golden model of Sd/cs. cs sequence logged per cycle matches the model.
- Drop io_tx_enable after 4 data bytes → two CSR symbols, then cs=000, then (+2,+2,+2,+2), then (+2,+2,+2,-2), then IDLE.
- Hold io_tx_error=1 on the ESD2 cycle → ESD2 = (-2,+2,+2,+2). io_tx_error=1 during DATA → (-2,+2,+2,+2) that cycle.
- io_tx_mode=0 mid-frame → next outputs all 0 and FSM returns to IDLE. io_n==io_n0 → Scr reloads to {1, io_n0}.
